// File: rtl/fetch_queue_reg_pkg.sv
// Shared pipeline definitions for the IF/ID fetch queue: NOP encoding,
// default datapath width and a constant-foldable clog2 helper.
package fetch_queue_reg_pkg;

  localparam int          DEFAULT_DATA_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

  // Elaboration-time ceil(log2(value)); returns at least 1 so a pointer always has a bit.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrapping PTR_W-bit queue pointer with async reset, synchronous clear
// and increment enable; wraps naturally because DEPTH is a power of two.
module fetch_queue_ptr #(
  parameter int PTR_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue_reg.sv
// IF/ID stage as a DEPTH-entry FIFO of {pc_plus_four, instruction} with valid/ready handshake.
// Optional FETCH_QUEUE_HWM_EN adds a high_water occupancy output.
module fetch_queue_reg
  import fetch_queue_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid_F,
  input  logic [DATA_WIDTH-1:0] pc_plus_four_F,
  input  logic [DATA_WIDTH-1:0] instruction_F,
  output logic                  ready_F,
  input  logic                  StallD,
  output logic                  valid_D,
  output logic [DATA_WIDTH-1:0] pc_plus_four_D,
  output logic [DATA_WIDTH-1:0] instruction_D,
`ifdef FETCH_QUEUE_HWM_EN
  output logic [CNT_W-1:0]      high_water,
`endif
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = clog2_f(DEPTH);

  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Handshake depends only on registered occupancy, never on StallD or F inputs.
  assign ready_F = (count_q != CNT_W'(DEPTH));
  assign valid_D = (count_q != '0);
  assign push    = valid_F & ready_F & ~clear;
  assign pop     = valid_D & ~StallD & ~clear;

  fetch_queue_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clear),
    .inc_i   (pop),
    .ptr_o   (rd_ptr)
  );

  fetch_queue_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clear),
    .inc_i   (push),
    .ptr_o   (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; count/valid gate every read, so stale data is never observed.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr]    <= pc_plus_four_F;
      instr_mem_q[wr_ptr] <= instruction_F;
    end
  end

  assign pc_plus_four_D = valid_D ? pc_mem_q[rd_ptr]    : '0;
  assign instruction_D  = valid_D ? instr_mem_q[rd_ptr] : DATA_WIDTH'(NOP_INSTR);
  assign count          = count_q;

`ifdef FETCH_QUEUE_HWM_EN
  logic [CNT_W-1:0] high_water_q;

  // Tracks the next count so the mark moves in the same cycle the occupancy does; clear never lowers it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_water_q <= '0;
    end else if (count_d > high_water_q) begin
      high_water_q <= count_d;
    end
  end

  assign high_water = high_water_q;
`endif

endmodule

// File: tb/tb_fetch_queue_reg.sv
// Directed table-driven bench for fetch_queue_reg (DEPTH=2) plus hand-written
// async-reset and no-combinational-path sequences.
module tb_fetch_queue_reg;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset;
  logic             clear;
  logic             valid_F;
  logic [DW-1:0]    pc_plus_four_F;
  logic [DW-1:0]    instruction_F;
  logic             ready_F;
  logic             StallD;
  logic             valid_D;
  logic [DW-1:0]    pc_plus_four_D;
  logic [DW-1:0]    instruction_D;
  logic [CNT_W-1:0] count;
`ifdef FETCH_QUEUE_HWM_EN
  logic [CNT_W-1:0] high_water;
`endif

  fetch_queue_reg #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .valid_F        (valid_F),
    .pc_plus_four_F (pc_plus_four_F),
    .instruction_F  (instruction_F),
    .ready_F        (ready_F),
    .StallD         (StallD),
    .valid_D        (valid_D),
    .pc_plus_four_D (pc_plus_four_D),
    .instruction_D  (instruction_D),
`ifdef FETCH_QUEUE_HWM_EN
    .high_water     (high_water),
`endif
    .count          (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  typedef struct {
    logic          valid_f;
    logic [DW-1:0] pc_f;
    logic [DW-1:0] instr_f;
    logic          stall;
    logic          clr;
    logic          exp_valid;
    logic [DW-1:0] exp_pc;
    logic [DW-1:0] exp_instr;
    logic          exp_ready;
    logic [1:0]    exp_count;
  } vec_t;

  vec_t vecs[16];

  task automatic set_inputs(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                            input logic st, input logic cl);
    valid_F        = v;
    pc_plus_four_F = pc;
    instruction_F  = ins;
    StallD         = st;
    clear          = cl;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [DW-1:0] epc,
                               input logic [DW-1:0] eins, input logic erdy, input logic [1:0] ecnt);
    check({tag, ".valid_D"},        64'(valid_D),        64'(ev));
    check({tag, ".pc_plus_four_D"}, 64'(pc_plus_four_D), 64'(epc));
    check({tag, ".instruction_D"},  64'(instruction_D),  64'(eins));
    check({tag, ".ready_F"},        64'(ready_F),        64'(erdy));
    check({tag, ".count"},          64'(count),          64'(ecnt));
  endtask

  initial begin
    // Stimulus/expectation table, expectations are the state after the clock edge.
    //            vF  pc_f        instr_f        st  clr  eV  ePC         eINSTR         eRdy eCnt
    // Streaming two entries with no stall.
    vecs[0]  = '{1'b1, 32'h4,  32'h2002_0005, 1'b0, 1'b0, 1'b1, 32'h4,  32'h2002_0005, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 32'h8,  32'h2003_0007, 1'b0, 1'b0, 1'b1, 32'h8,  32'h2003_0007, 1'b1, 2'd1};
    vecs[2]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd0};
    // Fill under stall: A, B accepted; C refused while full.
    vecs[3]  = '{1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 32'h14, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 2'd2};
    vecs[5]  = '{1'b1, 32'h18, 32'h3333_3333, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 2'd2};
    // Full with pop: A popped, C refused that cycle; then C accepted as B pops.
    vecs[6]  = '{1'b1, 32'h18, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 32'h14, 32'h2222_2222, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 32'h18, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 32'h18, 32'h3333_3333, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd0};
    // Stall on empty queue does nothing.
    vecs[9]  = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd0};
    // Fill to two then flush with a valid F entry, which must be discarded.
    vecs[10] = '{1'b1, 32'h1c, 32'h4444_4444, 1'b0, 1'b0, 1'b1, 32'h1c, 32'h4444_4444, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 32'h20, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 32'h1c, 32'h4444_4444, 1'b0, 2'd2};
    vecs[12] = '{1'b1, 32'h24, 32'h6666_6666, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         1'b1, 2'd0};
    vecs[13] = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd0};
    vecs[14] = '{1'b1, 32'h28, 32'h7777_7777, 1'b0, 1'b0, 1'b1, 32'h28, 32'h7777_7777, 1'b1, 2'd1};
    vecs[15] = '{1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd0};

    // Reset then idle.
    set_inputs(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_outputs("in_reset", 1'b0, '0, '0, 1'b1, 2'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_outputs("idle", 1'b0, '0, '0, 1'b1, 2'd0);
`ifdef FETCH_QUEUE_HWM_EN
    check("idle.high_water", 64'(high_water), 64'd0);
`endif

    for (int i = 0; i < 16; i++) begin
      set_inputs(vecs[i].valid_f, vecs[i].pc_f, vecs[i].instr_f, vecs[i].stall, vecs[i].clr);
      @(posedge clock);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                    vecs[i].exp_instr, vecs[i].exp_ready, vecs[i].exp_count);
`ifdef FETCH_QUEUE_HWM_EN
      if (i == 12 || i == 13) begin
        check($sformatf("vec%0d.high_water", i), 64'(high_water), 64'd2);
      end
`endif
    end

    // No combinational F->D path: a valid F entry is invisible until the edge.
    set_inputs(1'b1, 32'h2c, 32'h8888_8888, 1'b1, 1'b0);
    #2;
    check("no_comb.valid_D",       64'(valid_D),       64'd0);
    check("no_comb.instruction_D", 64'(instruction_D), 64'd0);
    @(posedge clock);
    #1;
    set_inputs(1'b1, 32'h30, 32'h9999_9999, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check_outputs("pre_areset", 1'b1, 32'h2c, 32'h8888_8888, 1'b0, 2'd2);

    // Async reset mid-cycle while full and still pushing.
    #2;
    reset = 1'b1;
    #1;
    check_outputs("areset_now", 1'b0, '0, '0, 1'b1, 2'd0);
`ifdef FETCH_QUEUE_HWM_EN
    check("areset_now.high_water", 64'(high_water), 64'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    set_inputs(1'b1, 32'h34, 32'hAAAA_0001, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_outputs("post_areset", 1'b1, 32'h34, 32'hAAAA_0001, 1'b1, 2'd1);
    set_inputs(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_outputs("drain", 1'b0, '0, '0, 1'b1, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
